// File: rtl/weight_fetch_sequencer.sv
// Walks one neuron's weight memory across a dot-product pass, pairing each
// returned weight with its delayed input sample and marking first/last pairs.
module weight_fetch_sequencer #(
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [addressWidth:0]   num_inputs,
  input  logic [dataWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    wmem_ren,
  output logic [addressWidth:0]   wmem_raddr,
  input  logic [dataWidth-1:0]    wmem_rdata,
  output logic                    pair_valid,
  output logic [dataWidth-1:0]    pair_x,
  output logic [dataWidth-1:0]    pair_w,
  output logic                    pair_first,
  output logic                    pair_last,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = addressWidth + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        addr;
  logic [CW-1:0]        cnt_max;
  logic                 accept;
  logic                 at_first;
  logic                 at_last;
  logic                 vld_p1;
  logic                 first_p1;
  logic                 last_p1;
  logic [dataWidth-1:0] pair_x_p1;

  assign in_ready   = (state == RUN);
  assign accept     = in_valid & in_ready;
  assign at_first   = (addr == '0);
  // Equality termination means addr never needs to wrap, even at max count.
  assign at_last    = (addr == cnt_max - CW'(1));
  assign wmem_ren   = accept;
  assign wmem_raddr = addr;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      cnt_max <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (num_inputs != '0) begin
              cnt_max <= num_inputs;
              addr    <= '0;
              state   <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (accept) begin
            addr <= addr + CW'(1);
            if (at_last) state <= FLUSH;
          end
        end
        FLUSH:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: sample registered alongside the read so it meets the weight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
      last_p1   <= 1'b0;
      pair_x_p1 <= '0;
    end else begin
      vld_p1   <= accept;
      first_p1 <= accept & at_first;
      last_p1  <= accept & at_last;
      if (accept) pair_x_p1 <= in_data;
    end
  end

  assign pair_valid = vld_p1;
  assign pair_x     = pair_x_p1;
  assign pair_w     = wmem_rdata;
  assign pair_first = first_p1;
  assign pair_last  = last_p1;

endmodule
